shot_slot_scheduler: RTL

SHOT_SLOT_SCHEDULER -- requirements
Module: shot_slot_scheduler

---
 rtl/shot_slot_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/shot_slot_scheduler.sv
// Shot slot scheduler: arbitrates fire requests from the player and the turret
// onto a small pool of shot slots, with per-requester frame cooldowns.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | sample eligible requesters; go to ARB if any
// ARB    | pick round-robin winner; grant lowest free slot or deny
// LAUNCH | pulse launch/launchOwner for the slot reserved in ARB
module shot_slot_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int NUM_REQ         = 2,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic                                           clk,
  input  logic                                           resetN,
  input  logic                                           startOfFrame,
  input  logic                                           pause,
  input  logic [NUM_REQ-1:0]                             fireReq,
  input  logic [NUM_SLOTS-1:0]                           slotDone,
  output logic [NUM_SLOTS-1:0]                           launch,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] launchOwner,
  output logic [NUM_SLOTS-1:0]                           slotBusy,
  output logic [NUM_REQ-1:0]                             fireAck,
  output logic [NUM_REQ-1:0]                             fireDenied
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   elig_q, elig_d;
  logic [OW-1:0]        last_q, last_d;
  logic [NUM_SLOTS-1:0] slot_q, slot_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [NUM_SLOTS-1:0] launch_q, launch_d;
  logic [OW-1:0]        lown_q, lown_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   den_q, den_d;
  logic [CW-1:0]        cd_q [NUM_REQ];
  logic [CW-1:0]        cd_d [NUM_REQ];

  logic [NUM_REQ-1:0]   elig_now;
  logic                 win_found;
  logic [OW-1:0]        win;
  logic                 free_found;
  logic [SW-1:0]        free_idx;
  logic [NUM_SLOTS-1:0] alloc;
  logic [NUM_REQ-1:0]   load_full;
  logic [NUM_REQ-1:0]   load_one;

  // Eligibility, round-robin winner after last grant, and lowest free slot.
  always_comb begin
    elig_now   = '0;
    win_found  = 1'b0;
    win        = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_now[i] = fireReq[i] && (cd_q[i] == '0) && !pause;
    end
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (int'(last_q) + off) % NUM_REQ;
      if (!win_found && elig_q[idx]) begin
        win_found = 1'b1;
        win       = OW'(idx);
      end
    end
    // Uses the registered busy vector, so a slot freed this cycle is not seen.
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!free_found && !busy_q[k]) begin
        free_found = 1'b1;
        free_idx   = SW'(k);
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    elig_d    = elig_q;
    last_d    = last_q;
    slot_d    = slot_q;
    owner_d   = owner_q;
    launch_d  = '0;
    lown_d    = '0;
    ack_d     = '0;
    den_d     = '0;
    alloc     = '0;
    load_full = '0;
    load_one  = '0;
    case (state_q)
      S_IDLE: begin
        if (|elig_now) begin
          elig_d  = elig_now;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (free_found) begin
          alloc[free_idx] = 1'b1;
          ack_d[win]      = 1'b1;
          load_full[win]  = 1'b1;
          last_d          = win;
          slot_d          = alloc;
          owner_d         = win;
          state_d         = S_LAUNCH;
        end else begin
          den_d[win]    = 1'b1;
          load_one[win] = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_LAUNCH: begin
        launch_d = slot_q;
        lown_d   = owner_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot occupancy and cooldown next values; a load beats the frame decrement.
  always_comb begin
    busy_d = (busy_q & ~slotDone) | alloc;
    for (int i = 0; i < NUM_REQ; i++) begin
      cd_d[i] = cd_q[i];
      if (load_full[i]) begin
        cd_d[i] = CW'(COOLDOWN_FRAMES);
      end else if (load_one[i]) begin
        cd_d[i] = CW'(1);
      end else if (startOfFrame && !pause && (cd_q[i] != '0)) begin
        cd_d[i] = cd_q[i] - CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset drops any pending launch.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      elig_q   <= '0;
      last_q   <= OW'(NUM_REQ - 1);
      slot_q   <= '0;
      owner_q  <= '0;
      busy_q   <= '0;
      launch_q <= '0;
      lown_q   <= '0;
      ack_q    <= '0;
      den_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cd_q[i] <= '0;
      end
    end else begin
      elig_q   <= elig_d;
      last_q   <= last_d;
      slot_q   <= slot_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      launch_q <= launch_d;
      lown_q   <= lown_d;
      ack_q    <= ack_d;
      den_q    <= den_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cd_q[i] <= cd_d[i];
      end
    end
  end

  assign launch      = launch_q;
  assign launchOwner = lown_q;
  assign slotBusy    = busy_q;
  assign fireAck     = ack_q;
  assign fireDenied  = den_q;

endmodule
